// File: rtl/ysyx_22040895_dmem_resp_if.sv
// rtl/ysyx_22040895_dmem_resp_if.sv - load/store request and response bundle between MMU and data memory
interface ysyx_22040895_dmem_resp_if;
  logic        mce_i;
  logic        mwe_i;
  logic [1:0]  munit_i;
  logic [63:0] maddr_i;
  logic [63:0] wmdata_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [63:0] rmdata_o;
  logic        err_o;

  modport master (
    output mce_i, mwe_i, munit_i, maddr_i, wmdata_i,
    input  ready_o, rvalid_o, rmdata_o, err_o
  );

  modport slave (
    input  mce_i, mwe_i, munit_i, maddr_i, wmdata_i,
    output ready_o, rvalid_o, rmdata_o, err_o
  );
endinterface

// File: rtl/ysyx_22040895_dmem_resp.sv
// rtl/ysyx_22040895_dmem_resp.sv - single-outstanding data-memory responder with wait states and byte-lane stores
module ysyx_22040895_dmem_resp #(
  parameter int unsigned DEPTH   = 512,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22040895_dmem_resp_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  unit_q, unit_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH];

  logic             cur_we;
  logic [1:0]       cur_unit;
  logic [63:0]      cur_addr, cur_wdata;
  logic [63:0]      off;
  logic [IDX_W-1:0] idx;
  logic [2:0]       lane;
  logic             out_of_range, misaligned, acc_err, commit;
  logic [7:0]       size_mask, byte_en;
  logic [63:0]      wshift, rshift, rsize_mask;

  // With zero wait states the commit happens on the accept edge, so the live inputs stand in for the capture.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we    = bus.mwe_i;
      cur_unit  = bus.munit_i;
      cur_addr  = bus.maddr_i;
      cur_wdata = bus.wmdata_i;
    end else begin
      cur_we    = we_q;
      cur_unit  = unit_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign off          = cur_addr - BASE;
  assign idx          = off[3 +: IDX_W];
  assign lane         = off[2:0];
  assign out_of_range = (off >= SPAN);

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'hFF;
    case (cur_unit)
      2'b00: begin misaligned = 1'b0;     size_mask = 8'h01; end
      2'b01: begin misaligned = off[0];   size_mask = 8'h03; end
      2'b10: begin misaligned = |off[1:0]; size_mask = 8'h0F; end
      default: begin misaligned = |off[2:0]; size_mask = 8'hFF; end
    endcase
  end

  assign acc_err = out_of_range | misaligned;
  assign byte_en = size_mask << lane;
  assign wshift  = cur_wdata << {lane, 3'b000};
  assign rshift  = mem[idx] >> {lane, 3'b000};

  always_comb begin
    rsize_mask = '0;
    for (int b = 0; b < 8; b++) begin
      rsize_mask[8*b +: 8] = {8{size_mask[b]}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    unit_d  = unit_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mce_i) begin
          we_d    = bus.mwe_i;
          unit_d  = bus.munit_i;
          addr_d  = bus.maddr_i;
          wdata_d = bus.wmdata_i;
          cnt_d   = LAT4;
          state_d = (LAT4 != 4'd0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESP) begin
      err_d = acc_err;
      if (!acc_err && !cur_we) begin
        rdata_d = rshift & rsize_mask;
      end
    end
  end

  assign commit = (state_d == S_RESP) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      unit_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      unit_q  <= unit_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The array is deliberately not reset; contents survive a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !acc_err) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= wshift[8*b +: 8];
        end
      end
    end
  end

  assign bus.ready_o  = (state_q == S_IDLE);
  assign bus.rvalid_o = (state_q == S_RESP);
  assign bus.rmdata_o = rdata_q;
  assign bus.err_o    = err_q;
endmodule

// File: doc/ysyx_22040895_dmem_resp.md
Name: ysyx_22040895_dmem_resp

Overview:
- Data-memory responder at the far end of the core's load/store interface: the memory-management unit issues requests and this block answers them.
- Accepts one request at a time (address, write enable, access unit, store data) and holds it for a programmable number of wait states.
- Commits stores with byte-lane masking into an internal doubleword array, then returns load data or a write acknowledge with an error flag.
- Stands in for real data memory in simulation and early FPGA bring-up.

Parameters:
- DEPTH, 512, number of 64-bit doublewords in the array (power of two).
- BASE, 64'h8000_0000, byte address mapped to array index 0.
- LATENCY, 1, wait-state cycles between accept and response (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mce_i  in  1  request valid.
- mwe_i  in  1  1 = store, 0 = load.
- munit_i  in  2  access size: 00 byte, 01 half, 10 word, 11 doubleword.
- maddr_i  in  64  byte address.
- wmdata_i  in  64  store data, right-aligned (byte 0 in bits 7:0).
- ready_o  out  1  responder can accept a request this cycle.
- rvalid_o  out  1  one-cycle response strobe.
- rmdata_o  out  64  load data, right-aligned and zero-extended to the access size; requester sign-extends.
- err_o  out  1  qualifies rvalid_o: misaligned or out-of-range access.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; wait counter cleared; captured request cleared.
  - ready_o=1, rvalid_o=0, rmdata_o=0, err_o=0.
  - Array contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ready_o=1.
  - On mce_i=1 the request is accepted: address, we, unit and data are captured; counter is loaded with LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
  - mce_i=0 holds IDLE.
- WAIT:
  - ready_o=0; counter decrements each cycle.
  - On the edge where counter==1, next state is RESP.
  - Request inputs are ignored in WAIT.
- Commit edge (transition into RESP):
  - Access checked, store performed, load data registered.
  - Offset off = captured_addr - BASE.
  - Out of range when off >= DEPTH*8, including addr < BASE (unsigned wrap).
  - Misaligned when off[2:0] is not a multiple of the size: half needs off[0]=0; word needs off[1:0]=0; doubleword needs off[2:0]=0.
  - Index = off[3 +: log2(DEPTH)]; lane = off[2:0].
  - Store, no error: bytes lane .. lane+size-1 of array[index] replaced by the low size bytes of wmdata_i; all other bytes unchanged.
  - Load, no error: rmdata_o = (array[index] >> 8*lane) masked to size bytes.
  - Error: no array write; rmdata_o=0; err_o=1.
  - Store with no error: rmdata_o=0, err_o=0.
- RESP:
  - rvalid_o=1 for exactly one cycle; ready_o=0; next state IDLE unconditionally.
  - rvalid_o, err_o and rmdata_o return to 0 in IDLE.
- Latency: request accepted at edge T; rvalid_o high during cycle T+1+LATENCY. Back-to-back requests are spaced at least LATENCY+2 cycles.
- Ordering: a load accepted after a store's rvalid observes the stored data.
- Reset mid-transaction:
  - In WAIT, the request is dropped with no store and no response.
  - In RESP, the store is already committed and remains.
- mce_i while ready_o=0 is not a request; the requester must hold it until it sees ready_o=1.

Test Plan:
- Reset then LATENCY=1: store doubleword 64'h1122334455667788 at 0x80000010, then load doubleword at 0x80000010 -> store rvalid at T+2 with err=0; load rmdata=64'h1122334455667788.
- Byte-lane store: after the above, store byte 0xAB at 0x80000013, then load doubleword -> rmdata=64'h11223344AB667788; load half at 0x80000012 -> 64'h000000000000AB66.
- Misaligned: word load at 0x80000012 -> rvalid with err=1, rmdata=0. Doubleword store at 0x80000014 -> err=1 and array unchanged on readback.
- Range: load at 0x7FFFFFF8 and at BASE+DEPTH*8 -> err=1. Load at BASE+DEPTH*8-8 -> err=0.
- Timing: LATENCY=0 -> rvalid the cycle after accept. LATENCY=3 -> ready_o low for 4 cycles, rvalid at T+4; mce_i pulsed during WAIT is ignored.
- Reset asserted during WAIT of a store of 0xFF at 0x80000020 -> no rvalid; a later load at that address returns the previous value; outputs at reset are ready=1, rvalid=0, rmdata=0, err=0.
